// File: rtl/ft245_fifo_bridge.sv
// ft245_fifo_bridge: bridge between an FT245-style asynchronous USB FIFO chip
// and the fabric, with an RX FIFO (chip -> fabric) and a TX FIFO (fabric -> chip).
// Optional byte statistics: define FT245_STATS_EN to add rx_bytes/tx_bytes/stats_clr.
module ft245_fifo_bridge #(
  parameter int RX_DEPTH = 512,
  parameter int TX_DEPTH = 512,
  parameter int RD_PULSE = 4,
  parameter int WR_PULSE = 3,
  parameter int RECOVER  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxf_n,
  input  logic                        txe_n,
  output logic                        rd_n,
  output logic                        wr_n,
  inout  wire  [7:0]                  data,
  input  logic                        rx_rd_en,
  output logic [7:0]                  rx_dout,
  output logic                        rx_empty,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  input  logic [7:0]                  tx_din,
  input  logic                        tx_wr_en,
  output logic                        tx_full,
  output logic [$clog2(TX_DEPTH):0]   tx_count
`ifdef FT245_STATS_EN
  ,
  input  logic                        stats_clr,
  output logic [31:0]                 rx_bytes,
  output logic [31:0]                 tx_bytes
`endif
);

  localparam int RAW   = $clog2(RX_DEPTH);
  localparam int TAW   = $clog2(TX_DEPTH);
  localparam int MAX_P = (RD_PULSE > WR_PULSE) ? ((RD_PULSE > RECOVER) ? RD_PULSE : RECOVER)
                                               : ((WR_PULSE > RECOVER) ? WR_PULSE : RECOVER);
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [RAW:0]  RX_FULL  = (RAW+1)'(RX_DEPTH);
  localparam logic [TAW:0]  TX_FULL  = (TAW+1)'(TX_DEPTH);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_PULSE - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(RECOVER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_STROBE, S_WR_SETUP, S_WR_STROBE, S_WR_HOLD, S_RECOVER
  } state_t;
  typedef enum logic {DIR_RX, DIR_TX} dir_t;

  // ---------------- flag synchronisers ----------------
  logic rxf_meta_q, rxf_s_q, txe_meta_q, txe_s_q;

  // Two-flop synchronisers for the asynchronous chip flags (idle = 1)
  always_ff @(posedge clk) begin
    if (rst) begin
      rxf_meta_q <= 1'b1;
      rxf_s_q    <= 1'b1;
      txe_meta_q <= 1'b1;
      txe_s_q    <= 1'b1;
    end else begin
      rxf_meta_q <= rxf_n;
      rxf_s_q    <= rxf_meta_q;
      txe_meta_q <= txe_n;
      txe_s_q    <= txe_meta_q;
    end
  end

  // ---------------- FIFO storage and state ----------------
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [RAW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [TAW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [RAW:0]   rx_count_q, rx_count_d;
  logic [TAW:0]   tx_count_q, tx_count_d;
  logic [7:0]     rx_dout_q;
  logic           rx_push, rx_pop, tx_push, tx_pop, load_data;

  assign rx_pop  = rx_rd_en && (rx_count_q != '0);
  assign tx_push = tx_wr_en && (tx_count_q != TX_FULL);

  // Occupancy next-state: simultaneous push and pop leaves the count unchanged
  always_comb begin
    rx_count_d = rx_count_q;
    tx_count_d = tx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase
  end

  // RAM write ports (no reset so they map onto block RAM)
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= data;
    if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_din;
  end

  // FIFO pointers, counts and the registered RX read port
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_count_q  <= '0;
      rx_dout_q   <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      if (rx_pop) begin
        rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
        rx_dout_q   <= rx_mem[rx_rd_ptr_q];
      end
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign rx_dout  = rx_dout_q;
  assign rx_count = rx_count_q;
  assign tx_count = tx_count_q;
  assign rx_empty = (rx_count_q == '0);
  assign tx_full  = (tx_count_q == TX_FULL);

  // ---------------- chip-side FSM ----------------
  state_t        state_q, state_d;
  dir_t          last_dir_q, last_dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_q, oe_d;
  logic [7:0]    data_o_q;
  logic          rx_ok, tx_ok;

  // RX writes land at the end of RD_STROBE, so in IDLE the count is already current
  assign rx_ok = !rxf_s_q && (rx_count_q != RX_FULL);
  assign tx_ok = !txe_s_q && (tx_count_q != '0);

  // Next-state and next-output decode; strobes and oe are registered from these
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    cnt_d      = cnt_q;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    oe_d       = 1'b0;
    rx_push    = 1'b0;
    tx_pop     = 1'b0;
    load_data  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_ok && (!tx_ok || last_dir_q == DIR_TX)) begin
          state_d = S_RD_STROBE;
          rd_n_d  = 1'b0;
        end else if (tx_ok) begin
          state_d   = S_WR_SETUP;
          oe_d      = 1'b1;
          load_data = 1'b1;
        end
      end
      S_RD_STROBE: begin
        if (cnt_q == RD_LAST) begin
          rx_push    = 1'b1;
          state_d    = S_RECOVER;
          cnt_d      = '0;
          last_dir_d = DIR_RX;
        end else begin
          rd_n_d = 1'b0;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      S_WR_SETUP: begin
        oe_d    = 1'b1;
        wr_n_d  = 1'b0;
        state_d = S_WR_STROBE;
        cnt_d   = '0;
      end
      S_WR_STROBE: begin
        oe_d = 1'b1;
        if (cnt_q == WR_LAST) begin
          tx_pop  = 1'b1;
          state_d = S_WR_HOLD;
        end else begin
          wr_n_d = 1'b0;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      S_WR_HOLD: begin
        state_d    = S_RECOVER;
        cnt_d      = '0;
        last_dir_d = DIR_TX;
      end
      S_RECOVER: begin
        if (cnt_q == REC_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered chip-side outputs; TX head is latched entering WR_SETUP
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_dir_q <= DIR_TX;
      cnt_q      <= '0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      data_o_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      cnt_q      <= cnt_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      oe_q       <= oe_d;
      if (load_data) data_o_q <= tx_mem[tx_rd_ptr_q];
    end
  end

  assign rd_n = rd_n_q;
  assign wr_n = wr_n_q;
  assign data = oe_q ? data_o_q : 8'hzz;

`ifdef FT245_STATS_EN
  logic [31:0] rx_bytes_q, rx_bytes_d, tx_bytes_q, tx_bytes_d;

  // Byte counters; a clear wins over a same-cycle increment
  always_comb begin
    rx_bytes_d = stats_clr ? 32'd0 : rx_bytes_q + 32'(rx_push);
    tx_bytes_d = stats_clr ? 32'd0 : tx_bytes_q + 32'(tx_pop);
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_bytes_q <= '0;
      tx_bytes_q <= '0;
    end else begin
      rx_bytes_q <= rx_bytes_d;
      tx_bytes_q <= tx_bytes_d;
    end
  end

  assign rx_bytes = rx_bytes_q;
  assign tx_bytes = tx_bytes_q;
`endif

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Bench for ft245_fifo_bridge with an FT245 chip model and queue-based scoreboard.
// Instantiated with RX_DEPTH = TX_DEPTH = 4 so the full boundaries are reachable.
module tb_ft245_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxf_n = 1'b1;
  logic       txe_n = 1'b1;
  logic       rd_n, wr_n;
  wire  [7:0] data;
  logic       rx_rd_en = 1'b0;
  logic [7:0] rx_dout;
  logic       rx_empty;
  logic [2:0] rx_count;
  logic [7:0] tx_din = 8'h00;
  logic       tx_wr_en = 1'b0;
  logic       tx_full;
  logic [2:0] tx_count;
`ifdef FT245_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] rx_bytes, tx_bytes;
`endif

  ft245_fifo_bridge #(
    .RX_DEPTH(4), .TX_DEPTH(4), .RD_PULSE(4), .WR_PULSE(3), .RECOVER(3)
  ) dut (
    .clk(clk), .rst(rst), .rxf_n(rxf_n), .txe_n(txe_n),
    .rd_n(rd_n), .wr_n(wr_n), .data(data),
    .rx_rd_en(rx_rd_en), .rx_dout(rx_dout), .rx_empty(rx_empty), .rx_count(rx_count),
    .tx_din(tx_din), .tx_wr_en(tx_wr_en), .tx_full(tx_full), .tx_count(tx_count)
`ifdef FT245_STATS_EN
    , .stats_clr(stats_clr), .rx_bytes(rx_bytes), .tx_bytes(tx_bytes)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- chip model ----------------
  logic [7:0] chip_q[$];
  logic [7:0] chip_byte = 8'h00;
  logic [7:0] chip_dummy;
  logic       chip_hold = 1'b0;

  assign data = (!rd_n) ? chip_byte : 8'hzz;

  always @(posedge rd_n) if (chip_q.size() > 0) chip_dummy = chip_q.pop_front();

  always @(negedge clk) begin
    rxf_n     = chip_hold || (chip_q.size() == 0);
    chip_byte = (chip_q.size() > 0) ? chip_q[0] : 8'h00;
  end

  // ---------------- scoreboard queues ----------------
  logic [7:0] exp_rx[$];   // bytes expected on rx_dout pops
  logic [7:0] exp_tx[$];   // bytes expected written into the chip
  logic       exp_dir[$];  // 0 = read strobe, 1 = write strobe, in order

  // ---------------- monitor ----------------
  logic       mon_en = 1'b0;
  logic       rd_prev = 1'b1, wr_prev = 1'b1, rd_active = 1'b0, wr_active = 1'b0;
  logic       rx_pop_pend = 1'b0;
  int         rd_len = 0, wr_len = 0, hi_len = 100;
  int         rd_falls = 0, wr_falls = 0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] m_tmp;
  logic       m_dir;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      rd_prev = 1'b1; wr_prev = 1'b1; rd_active = 1'b0; wr_active = 1'b0;
      rx_pop_pend = 1'b0; hi_len = 100;
    end else begin
      if (!rd_n) chk("bus_safety_oe_during_rd", {31'd0, dut.oe_q}, 32'd0);
      // read strobe
      if (!rd_n && rd_prev) begin
        rd_falls++; rd_active = 1'b1; rd_len = 1;
        n_checks++;
        if (hi_len < 3) begin
          n_errors++;
          $display("FAIL rd_gap: %0d high cycles before rd_n fall, required >= 3", hi_len);
        end
        if (exp_dir.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL strobe_order: unexpected rd_n fall, required none");
        end else begin
          m_dir = exp_dir.pop_front();
          chk("strobe_order_rd", 32'd0, {31'd0, m_dir});
        end
      end else if (!rd_n) begin
        rd_len++;
      end else if (rd_prev == 1'b0 && rd_n) begin
        if (rd_active) begin
          chk("rd_pulse_len", rd_len, 32'd4);
          $display("chip read strobe done (%0d cycles low)", rd_len);
        end
        rd_active = 1'b0; hi_len = 1;
      end else begin
        hi_len++;
      end
      rd_prev = rd_n;
      // write strobe
      if (!wr_n && wr_prev) begin
        wr_falls++; wr_active = 1'b1; wr_len = 1; wr_data = data;
        chk("wr_oe_during_strobe", {31'd0, dut.oe_q}, 32'd1);
        if (exp_tx.size() > 0) chk("wr_setup_data", data, exp_tx[0]);
        if (exp_dir.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL strobe_order: unexpected wr_n fall with data 0x%0h, required none", data);
        end else begin
          m_dir = exp_dir.pop_front();
          chk("strobe_order_wr", 32'd1, {31'd0, m_dir});
        end
      end else if (!wr_n) begin
        wr_len++;
        chk("wr_data_stable", data, wr_data);
      end else if (wr_prev == 1'b0 && wr_n && wr_active) begin
        chk("wr_pulse_len", wr_len, 32'd3);
        chk("wr_hold_data", data, wr_data);
        if (exp_tx.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL chip_wr: unexpected byte 0x%0h, required none", wr_data);
        end else begin
          m_tmp = exp_tx.pop_front();
          chk("chip_wr_byte", wr_data, m_tmp);
        end
        $display("chip received byte 0x%02h", wr_data);
        wr_active = 1'b0;
      end
      wr_prev = wr_n;
      // RX pop data (read latency 1)
      if (rx_pop_pend) begin
        if (exp_rx.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rx_pop: unexpected byte 0x%0h, required none", rx_dout);
        end else begin
          m_tmp = exp_rx.pop_front();
          chk("rx_dout", rx_dout, m_tmp);
          $display("fabric popped byte 0x%02h", rx_dout);
        end
      end
      rx_pop_pend = rx_rd_en && !rx_empty;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_tx(input logic [7:0] b);
    tx_din = b; tx_wr_en = 1'b1;
    @(posedge clk); #1;
    tx_wr_en = 1'b0;
  endtask

  task automatic pop_rx(input int n);
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (rx_empty && w < 600) begin @(posedge clk); #1; w++; end
      if (rx_empty) begin
        n_checks++; n_errors++;
        $display("FAIL pop_wait: rx_empty stuck at 1, required 0");
      end
      rx_rd_en = 1'b1;
      @(posedge clk); #1;
      rx_rd_en = 1'b0;
    end
  endtask

  task automatic chip_push(input logic [7:0] b);
    chip_q.push_back(b);
    exp_rx.push_back(b);
    exp_dir.push_back(1'b0);
  endtask

  task automatic fab_push(input logic [7:0] b);
    exp_tx.push_back(b);
    exp_dir.push_back(1'b1);
    push_tx(b);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk); #1;
    chk("rst_rd_n", rd_n, 1); chk("rst_wr_n", wr_n, 1);
    chk("rst_oe", dut.oe_q, 0); chk("rst_rx_dout", rx_dout, 0);
    chk("rst_rx_empty", rx_empty, 1); chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_count", rx_count, 0); chk("rst_tx_count", tx_count, 0);
    rst = 1'b0; mon_en = 1'b1;
    repeat (3) @(posedge clk); #1;

    // ---- 1: three chip reads ----
    base = rd_falls;
    chip_push(8'hA5); chip_push(8'h5A); chip_push(8'hFF);
    for (int i = 0; i < 500 && rx_count != 3'd3; i++) begin @(posedge clk); #1; end
    repeat (20) @(posedge clk); #1;
    chk("t1_rx_count", rx_count, 3);
    chk("t1_rd_falls", rd_falls - base, 3);
    pop_rx(3);
    chk("t1_rx_empty", rx_empty, 1);
    rx_rd_en = 1'b1; @(posedge clk); #1; rx_rd_en = 1'b0;   // pop while empty
    @(posedge clk); #1;
    chk("t1_empty_pop_count", rx_count, 0);
    chk("t1_empty_pop_dout", rx_dout, 8'hFF);

    // ---- 2: four fabric writes ----
    txe_n = 1'b0;
    base = wr_falls;
    for (int b = 1; b <= 4; b++) fab_push(8'(b));
    for (int i = 0; i < 1000 && (tx_count != 3'd0 || exp_tx.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk); #1;
    chk("t2_tx_count", tx_count, 0);
    chk("t2_wr_falls", wr_falls - base, 4);

    // ---- 3: both directions ready -> alternate RD, WR, RD, WR ----
    chip_hold = 1'b1; txe_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      exp_tx.push_back(8'h81 + 8'(k)); push_tx(8'h81 + 8'(k));
    end
    chk("t3_tx_full", tx_full, 1);
    chk("t3_tx_count", tx_count, 4);
    for (int k = 0; k < 4; k++) begin
      chip_q.push_back(8'h11 * 8'(k + 1)); exp_rx.push_back(8'h11 * 8'(k + 1));
      exp_dir.push_back(1'b0); exp_dir.push_back(1'b1);
    end
    chip_hold = 1'b0; txe_n = 1'b0;
    for (int i = 0; i < 2000 && (exp_dir.size() != 0 || tx_count != 3'd0); i++) begin
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk); #1;
    chk("t3_dir_queue_drained", exp_dir.size(), 0);
    chk("t3_rx_count", rx_count, 4);
    pop_rx(4);

    // ---- 4: RX full stalls chip reads ----
    txe_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    base = rd_falls;
    for (int k = 0; k < 6; k++) begin
      chip_q.push_back(8'h60 + 8'(k)); exp_rx.push_back(8'h60 + 8'(k));
    end
    for (int k = 0; k < 4; k++) exp_dir.push_back(1'b0);
    for (int i = 0; i < 1000 && rx_count != 3'd4; i++) begin @(posedge clk); #1; end
    repeat (30) @(posedge clk); #1;
    chk("t4_rd_falls_full", rd_falls - base, 4);
    exp_dir.push_back(1'b0);
    pop_rx(1);
    repeat (30) @(posedge clk); #1;
    chk("t4_rd_falls_after_pop", rd_falls - base, 5);
    chk("t4_rx_count", rx_count, 4);
    exp_dir.push_back(1'b0);
    pop_rx(5);
    repeat (10) @(posedge clk); #1;
    chk("t4_rx_count_end", rx_count, 0);

    // ---- 5: push while full ignored; reset during WR_STROBE ----
    for (int k = 0; k < 4; k++) push_tx(8'hC1 + 8'(k));
    push_tx(8'hEE);
    chk("t5_full_count", tx_count, 4);
    chk("t5_full_flag", tx_full, 1);
    exp_tx.push_back(8'hC1); exp_dir.push_back(1'b1);
    txe_n = 1'b0;
    for (int i = 0; i < 200 && wr_n != 1'b0; i++) @(negedge clk);
    chk("t5_wr_started", wr_n, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_wr_n", wr_n, 1); chk("t5_rst_rd_n", rd_n, 1);
    chk("t5_rst_oe", dut.oe_q, 0); chk("t5_rst_tx_count", tx_count, 0);
    chk("t5_rst_tx_full", tx_full, 0);
    if (exp_tx.size() > 0) m_tmp = exp_tx.pop_front();
    rst = 1'b0;
    base = wr_falls;
    repeat (30) @(posedge clk); #1;
    chk("t5_no_write_after_rst", wr_falls - base, 0);

`ifdef FT245_STATS_EN
    // ---- 6: statistics ----
    for (int k = 0; k < 5; k++) chip_push(8'h70 + 8'(k));
    pop_rx(5);
    fab_push(8'h90); fab_push(8'h91);
    for (int i = 0; i < 1000 && (exp_dir.size() != 0 || tx_count != 3'd0); i++) begin
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk); #1;
    chk("t6_rx_bytes", rx_bytes, 5);
    chk("t6_tx_bytes", tx_bytes, 2);
    chip_push(8'h7F);
    for (int i = 0; i < 200 && rd_n != 1'b0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    chk("t6_clr_rx_bytes", rx_bytes, 0);
    chk("t6_clr_tx_bytes", tx_bytes, 0);
    chk("t6_clr_capture_done", rx_count, 1);
    pop_rx(1);
    repeat (5) @(posedge clk); #1;
`endif

    // ---- scoreboard drained ----
    repeat (5) @(posedge clk); #1;
    chk("end_exp_dir_empty", exp_dir.size(), 0);
    chk("end_exp_rx_empty", exp_rx.size(), 0);
    chk("end_exp_tx_empty", exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ft245_fifo_bridge.md
Name: ft245_fifo_bridge

Overview:
- Parametrised native-RTL bridge between an FT245-style asynchronous USB FIFO chip and the fabric; no HLS core.
- Contains an RX FIFO (chip to fabric) and a TX FIFO (fabric to chip), with configurable depths.
- Read/write strobe widths and recovery time are configurable.
- Round-robin arbitration between directions; synchronised chip flags; occupancy outputs.

Parameters:
- RX_DEPTH, 512: RX FIFO entries; power of 2, ≥4.
- TX_DEPTH, 512: TX FIFO entries; power of 2, ≥4.
- RD_PULSE, 4: cycles rd_n held low; data sampled on the last of them; ≥2.
- WR_PULSE, 3: cycles wr_n held low; ≥1.
- RECOVER, 3: cycles with both strobes high after a transfer; ≥3, covers the 2-flop flag synchroniser.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rxf_n  in  1  chip has RX data (low = data available); asynchronous.
- txe_n  in  1  chip can accept TX data (low = space available); asynchronous.
- rd_n  out  1  chip read strobe, active low.
- wr_n  out  1  chip write strobe, active low.
- data  inout  8  chip data bus; driven only while oe is internally high, else 8'hzz.
- rx_rd_en  in  1  pop RX FIFO.
- rx_dout  out  8  RX data.
- rx_empty  out  1  RX FIFO empty.
- rx_count  out  $clog2(RX_DEPTH)+1  RX occupancy.
- tx_din  in  8  TX data.
- tx_wr_en  in  1  push TX FIFO.
- tx_full  out  1  TX FIFO full.
- tx_count  out  $clog2(TX_DEPTH)+1  TX occupancy.

Behaviour:
- Reset: rd_n=1, wr_n=1, oe=0, rx_dout=0, both FIFOs emptied, counts=0, rx_empty=1, tx_full=0, FSM=IDLE, arbiter last_dir=TX.
- Reset mid-transfer: in-flight byte discarded; strobes high and bus released on the next clk edge.
- Synchronisation: rxf_n and txe_n pass through 2-flop synchronisers (reset value 1). Only the synchronised values rxf_s and txe_s are used.
- Eligibility:
  - rx_ok = !rxf_s && rx_count<RX_DEPTH (counting a write pending from the current transfer).
  - tx_ok = !txe_s && !tx_empty_int.
- IDLE:
  - If both rx_ok and tx_ok: serve the direction opposite last_dir.
  - Otherwise serve whichever one is ok; stay in IDLE if neither.
  - Decision made in the cycle the conditions hold; strobe/oe change registered on the next edge.
- RD_STROBE:
  - rd_n=0 for RD_PULSE cycles; oe=0 throughout.
  - On the last cycle, data is captured and written into the RX FIFO.
  - Then go to RECOVER; last_dir=RX.
- WR_SETUP: one cycle; oe=1, data_o=TX head, wr_n=1.
- WR_STROBE:
  - wr_n=0 for WR_PULSE cycles; data stable.
  - TX FIFO popped on the last cycle.
- WR_HOLD: one cycle; wr_n=1, oe=1, data unchanged. Then go to RECOVER with oe=0; last_dir=TX.
- RECOVER: RECOVER cycles, rd_n=wr_n=1, oe=0; then IDLE.
- Bus safety invariant: rd_n=0 and oe=1 never occur in the same cycle; oe is 0 for at least RECOVER cycles before any rd_n fall.
- Throughput per byte:
  - Read: 1+RD_PULSE+RECOVER cycles (IDLE included).
  - Write: 1+1+WR_PULSE+1+RECOVER cycles.
- FIFOs:
  - Synchronous, same clk; read latency 1 (rx_dout updates the edge after rx_rd_en with !rx_empty).
  - rx_rd_en while empty and tx_wr_en while full are ignored; no pointer or count change.
  - Simultaneous push+pop: count unchanged.
  - Pointers wrap modulo depth; full/empty derived from count.
  - tx_full, rx_empty and counts are registered and reflect all operations up to the previous edge.
- An RX write never overflows: rx_ok excludes the full case, and the fabric can only pop.

Optional Feature:
FT245_STATS_EN:
- When defined, adds output ports rx_bytes[31:0], tx_bytes[31:0] and input stats_clr.
- rx_bytes increments on each chip-read capture; tx_bytes increments on each TX pop into the chip.
- Both counters wrap at 2^32 and reset to 0 on rst or stats_clr; stats_clr has priority over an increment in the same cycle.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Hold rxf_n=0 and push 3 bytes on the chip model (0xA5, 0x5A, 0xFF), defaults → 3 rd_n pulses, each 4 cycles low, spaced ≥3 high cycles apart; rx_count=3; popping yields 0xA5, 0x5A, 0xFF; rx_empty=1 after the third pop.
- Push tx_din 0x01..0x04 with txe_n=0 → 4 wr_n pulses, each 3 cycles low; data stable from WR_SETUP through WR_HOLD; chip model receives 0x01..0x04; tx_count returns to 0.
- rxf_n=0 and txe_n=0 continuously, TX FIFO holding 4 bytes → transfers alternate RD, WR, RD, WR; checker confirms no cycle has rd_n=0 and oe=1.
- Fill RX to RX_DEPTH=4 (instantiated depth 4) with rxf_n held low → no 5th rd_n fall. Pop 1 → exactly one further read, then stall again.
- tx_wr_en at full with din 0xEE → tx_count stays 4 and 0xEE is never emitted. Assert rst during WR_STROBE → wr_n=1 and data=z on the next edge; tx_count=0.
- With FT245_STATS_EN: 5 reads and 2 writes → rx_bytes=5, tx_bytes=2. stats_clr coinciding with a capture → both counters =0 the next cycle.
